// File: rtl/cordic_seq_pkg.sv
// Shared constants and types for the CORDIC sequencer and its quadrant fold.
package cordic_seq_pkg;

  localparam int W_DEF    = 16;
  localparam int OW_DEF   = 17;
  localparam int ITER_DEF = 16;
  localparam int CNT_W    = 4;  // width of the core's iteration counter

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam logic [OW_DEF-1:0] OW_MAX = {1'b0, {(OW_DEF-1){1'b1}}};
  localparam logic [OW_DEF-1:0] OW_MIN = {1'b1, {(OW_DEF-1){1'b0}}};

endpackage

// File: rtl/cordic_quad_fix.sv
// Combinational quadrant fold: swaps/negates the core's first-quadrant
// result to restore the requested quadrant. Negation saturates so the
// most-negative code never wraps back onto itself.
module cordic_quad_fix
  import cordic_seq_pkg::*;
#(
  parameter int OW = OW_DEF
) (
  input  logic [OW-1:0] c,
  input  logic [OW-1:0] s,
  input  logic [1:0]    quad,
  output logic [OW-1:0] cos_o,
  output logic [OW-1:0] sin_o
);

  localparam logic [OW-1:0] V_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] V_MIN = {1'b1, {(OW-1){1'b0}}};

  function automatic logic [OW-1:0] sat_neg(input logic [OW-1:0] v);
    return (v == V_MIN) ? V_MAX : (~v + {{(OW-1){1'b0}}, 1'b1});
  endfunction

  // select swap/negate pattern for the requested quadrant
  always_comb begin
    cos_o = c;
    sin_o = s;
    case (quad)
      QUAD_1: begin cos_o = sat_neg(s); sin_o = c;          end
      QUAD_2: begin cos_o = sat_neg(c); sin_o = sat_neg(s); end
      QUAD_3: begin cos_o = s;          sin_o = sat_neg(c); end
      default: ;
    endcase
  end

endmodule

// File: rtl/cordic_seq.sv
// Request/response sequencer around the free-running iterative CORDIC core:
// loads the core, counts its iterations, captures and quadrant-corrects
// the final result and holds it until the consumer takes it.
module cordic_seq
  import cordic_seq_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int OW   = OW_DEF,
  parameter int ITER = ITER_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_theta,
  input  logic          req_sign,
  input  logic [1:0]    req_quad,
  output logic [W-1:0]  core_theta,
  output logic          core_sign,
  output logic          core_reset,
  input  logic [OW-1:0] core_cos,
  input  logic [OW-1:0] core_sin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] cos_out,
  output logic [OW-1:0] sin_out,
  output logic          busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      theta_q, theta_d;
  logic              sign_q, sign_d;
  logic [1:0]        quad_q, quad_d;
  logic [OW-1:0]     cos_q, cos_d, sin_q, sin_d;
  logic              out_valid_q, out_valid_d;
  logic [OW-1:0]     fix_cos, fix_sin;

  cordic_quad_fix #(.OW(OW)) u_fix (
    .c     (core_cos),
    .s     (core_sin),
    .quad  (quad_q),
    .cos_o (fix_cos),
    .sin_o (fix_sin)
  );

  // core inputs follow the latches always; the core only samples them in LOAD
  assign core_theta = theta_q;
  assign core_sign  = sign_q;
  assign out_valid  = out_valid_q;
  assign cos_out    = cos_q;
  assign sin_out    = sin_q;

  // next-state, latch updates and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    theta_d     = theta_q;
    sign_d      = sign_q;
    quad_d      = quad_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    out_valid_d = out_valid_q;
    req_ready   = 1'b0;
    core_reset  = 1'b1;
    busy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          theta_d = req_theta;
          sign_d  = req_sign;
          quad_d  = req_quad;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cos_d       = fix_cos;
          sin_d       = fix_sin;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        req_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (req_valid) begin
            theta_d = req_theta;
            sign_d  = req_sign;
            quad_d  = req_quad;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any request in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      theta_q     <= '0;
      sign_q      <= 1'b0;
      quad_q      <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      theta_q     <= theta_d;
      sign_q      <= sign_d;
      quad_q      <= quad_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cordic_seq.sv
// Scoreboard bench for cordic_seq with a stub core driving constant results.
module tb_cordic_seq;
  import cordic_seq_pkg::*;

  localparam int W = 16, OW = 17, ITER = 16;
  localparam int LAT = ITER + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_sign;
  logic [W-1:0]  req_theta;
  logic [1:0]    req_quad;
  logic [W-1:0]  core_theta;
  logic          core_sign, core_reset;
  logic [OW-1:0] core_cos, core_sin;
  logic          out_valid, out_ready, busy;
  logic [OW-1:0] cos_out, sin_out;

  cordic_seq #(.W(W), .OW(OW), .ITER(ITER)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_theta(req_theta), .req_sign(req_sign), .req_quad(req_quad),
    .core_theta(core_theta), .core_sign(core_sign), .core_reset(core_reset),
    .core_cos(core_cos), .core_sin(core_sin), .out_valid(out_valid),
    .out_ready(out_ready), .cos_out(cos_out), .sin_out(sin_out), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OW-1:0] c;
    logic [OW-1:0] s;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [W-1:0]  exp_theta = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor: checks LOAD theta, then result/latency/run length on each new out_valid
  initial begin : monitor
    bit   chk_done = 0;
    int   low_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        chk_done = 0;
        low_cnt  = 0;
      end else begin
        if (!core_reset) low_cnt++;
        if (busy && core_reset) check("load_theta", 32'(core_theta), 32'(exp_theta));
        if (out_valid && !chk_done) begin
          chk_done = 1;
          if (sb.size() == 0) begin
            check("unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check("cos_out", 32'(cos_out), 32'(e.c));
            check("sin_out", 32'(sin_out), 32'(e.s));
            check("latency", 32'(cyc - e.acc), 32'(LAT));
            check("run_cycles", 32'(low_cnt), 32'(ITER));
          end
          low_cnt = 0;
        end
        if (out_valid && out_ready) chk_done = 0;
      end
    end
  end

  // called at a negedge; issues one request and returns at the negedge after acceptance
  task automatic send(input logic [W-1:0] th, input logic sg, input logic [1:0] q,
                      input logic [OW-1:0] c, input logic [OW-1:0] s,
                      input logic [OW-1:0] ec, input logic [OW-1:0] es);
    int   n = 0;
    exp_t e;
    #1;
    while (!req_ready && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 200) check("req_ready_timeout", 32'(req_ready), 32'd1);
    core_cos  = c;
    core_sin  = s;
    req_theta = th;
    req_sign  = sg;
    req_quad  = q;
    exp_theta = th;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    e.c = ec; e.s = es; e.acc = cyc;
    sb.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [OW-1:0] held_c, held_s;
    int n;
    reset = 1'b0; req_valid = 1'b0; req_theta = '0; req_sign = 1'b0; req_quad = '0;
    core_cos = '0; core_sin = '0; out_ready = 1'b1;
    #3;
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_cos_out",    32'(cos_out),    32'd0);
    check("rst_sin_out",    32'(sin_out),    32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_core_theta", 32'(core_theta), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // quadrant sweep
    send(16'h1234, 1'b0, QUAD_0, 17'h04000, 17'h02000, 17'h04000, 17'h02000);
    send(16'h0456, 1'b1, QUAD_1, 17'h04000, 17'h02000, 17'h1E000, 17'h04000);
    send(16'h2000, 1'b0, QUAD_2, 17'h04000, 17'h02000, 17'h1C000, 17'h1E000);
    send(16'h7FFF, 1'b1, QUAD_3, 17'h04000, 17'h02000, 17'h02000, 17'h1C000);
    // saturating negate
    send(16'h0001, 1'b0, QUAD_1, 17'h04000, 17'h10000, 17'h0FFFF, 17'h04000);
    send(16'h0002, 1'b0, QUAD_2, 17'h10000, 17'h00000, 17'h0FFFF, 17'h00000);
    send(16'h0003, 1'b0, QUAD_0, 17'h10000, 17'h10000, 17'h10000, 17'h10000);
    // theta=0 style result: near-unity cos, tiny sin, then negated pair
    send(16'h0000, 1'b0, QUAD_0, 17'h0FFFF, 17'h00001, 17'h0FFFF, 17'h00001);
    send(16'h0000, 1'b0, QUAD_2, 17'h0FFFF, 17'h00001, 17'h10001, 17'h1FFFF);
    wait_valid();
    @(negedge clock);

    // backpressure: hold result, refuse a waiting request, then hand off back-to-back
    out_ready = 1'b0;
    send(16'h0AAA, 1'b0, QUAD_3, 17'h03000, 17'h01000, 17'h01000, 17'h1D000);
    wait_valid();
    held_c = cos_out; held_s = sin_out;
    req_valid = 1'b1; req_theta = 16'h5555; req_quad = QUAD_1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_cos_stable", 32'(cos_out),   32'(held_c));
      check("bp_sin_stable", 32'(sin_out),   32'(held_s));
      check("bp_req_ready",  32'(req_ready), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_not_busy",   32'(busy),      32'd0);
    end
    out_ready = 1'b1;
    send(16'h5555, 1'b0, QUAD_1, 17'h05000, 17'h00800, 17'h1F800, 17'h05000);
    check("b2b_load", 32'(busy && core_reset), 32'd1);
    wait_valid();
    @(negedge clock);

    // reset mid-RUN at cnt=7
    send(16'h0777, 1'b0, QUAD_0, 17'h01111, 17'h02222, 17'h01111, 17'h02222);
    repeat (8) @(negedge clock);
    check("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_out_valid",  32'(out_valid),  32'd0);
    check("abort_busy",       32'(busy),       32'd0);
    check("abort_core_reset", 32'(core_reset), 32'd1);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send(16'h0888, 1'b1, QUAD_2, 17'h00100, 17'h00200, 17'h1FF00, 17'h1FE00);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
